// File: rtl/fetch_unit.sv
// Instruction fetch front end: one outstanding bus request at a time, feeding a
// small {pc, instr} FIFO toward decode, with redirect/flush handling.
package fetch_pkg;
    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;
endpackage

module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'hbfc0_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        reset,
    output ibus_req_t   ireq,
    input  ibus_resp_t  iresp,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_IDLE} state_e;

    state_e        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   req_pc_q, req_pc_d;
    logic [31:0]   hold_addr_q, hold_addr_d;
    logic          hold_q, hold_d;
    logic          drop_q, drop_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [31:0]   pc_mem  [DEPTH];
    logic [31:0]   ins_mem [DEPTH];
    logic          push, pop;

    // An unaccepted request keeps its address even if fetch_pc is redirected underneath it.
    assign ireq.valid = (state_q == S_REQ) && !reset;
    assign ireq.addr  = hold_q ? hold_addr_q : fetch_pc_q;

    assign out_valid = (count_q != '0);
    assign out_pc    = pc_mem[rd_ptr_q];
    assign out_instr = ins_mem[rd_ptr_q];

    assign push = (state_q == S_WAIT) && iresp.data_ok && !drop_q && !redirect_valid;
    assign pop  = out_valid && out_ready;

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        req_pc_d    = req_pc_q;
        hold_addr_d = hold_addr_q;
        hold_d      = 1'b0;
        drop_d      = drop_q;
        rd_ptr_d    = rd_ptr_q + AW'(pop);
        wr_ptr_d    = wr_ptr_q + AW'(push);
        count_d     = count_q + CW'(push) - CW'(pop);

        if (redirect_valid) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end

        case (state_q)
            S_REQ: begin
                if (redirect_valid) drop_d = 1'b1;
                if (iresp.addr_ok) begin
                    req_pc_d = ireq.addr;
                    // While dropping, fetch_pc already holds the redirect target.
                    if (!drop_q) fetch_pc_d = fetch_pc_q + 32'd4;
                    state_d = S_WAIT;
                end else begin
                    hold_d      = 1'b1;
                    hold_addr_d = ireq.addr;
                end
            end
            S_WAIT: begin
                if (iresp.data_ok) begin
                    drop_d  = 1'b0;
                    state_d = (count_d < FULL) ? S_REQ : S_IDLE;
                end else if (redirect_valid) begin
                    drop_d = 1'b1;
                end
            end
            S_IDLE: begin
                if (redirect_valid || count_d < FULL) state_d = S_REQ;
            end
            default: state_d = S_REQ;
        endcase

        if (redirect_valid) fetch_pc_d = redirect_pc;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_REQ;
            fetch_pc_q  <= RESET_PC;
            req_pc_q    <= RESET_PC;
            hold_addr_q <= RESET_PC;
            hold_q      <= 1'b0;
            drop_q      <= 1'b0;
            count_q     <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            req_pc_q    <= req_pc_d;
            hold_addr_q <= hold_addr_d;
            hold_q      <= hold_d;
            drop_q      <= drop_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_q]  <= req_pc_q;
            ins_mem[wr_ptr_q] <= iresp.data;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: table of streaming phases against a bus model and
// scoreboard, then hand sequences for redirect and reset corners.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam logic [31:0] RPC = 32'hbfc0_0000;

    logic        clk = 1'b0;
    logic        reset;
    ibus_req_t   ireq;
    ibus_resp_t  iresp;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid, out_ready;
    logic [31:0] out_pc, out_instr;

    fetch_unit #(.RESET_PC(RPC), .DEPTH(4)) dut (
        .clk(clk), .reset(reset), .ireq(ireq), .iresp(iresp),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; logic [31:0] ins; } ent_t;
    typedef struct { int ncyc; int rdy_mode; int aok_pct; bit chk; bit exp_ivalid; } vec_t;

    ent_t        sbq[$];
    vec_t        vt[6];
    int          tests = 0, fails = 0;
    bit          pend;
    logic [31:0] pend_pc, exp_addr;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return 32'h2408_0001 + (a - RPC);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input bit aok, input bit dok, input logic [31:0] data,
                         input bit rdy, input bit rv, input logic [31:0] rpc);
        iresp.addr_ok  = aok;
        iresp.data_ok  = dok;
        iresp.data     = data;
        out_ready      = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        @(posedge clk);
        #1;
    endtask

    // Bus model: addr_ok at random, data_ok exactly one cycle after acceptance.
    task automatic cycle(input int rdy_mode, input int aok_pct);
        bit          aok, rdy, dok;
        logic [31:0] data;
        ent_t        e;
        aok = ireq.valid && ($urandom_range(0, 99) < aok_pct);
        rdy = (rdy_mode == 1) || (rdy_mode == 2 && $urandom_range(0, 1) == 1);
        if (out_valid && rdy) begin
            chk("pop_q_nonempty", 32'(sbq.size() != 0), 1);
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                chk("head_pc", out_pc, e.pc);
                chk("head_instr", out_instr, e.ins);
            end
        end
        if (aok) chk("req_addr", ireq.addr, exp_addr);
        dok  = pend;
        data = pend ? memf(pend_pc) : 32'h0;
        if (pend) sbq.push_back('{pend_pc, memf(pend_pc)});
        pend = aok;
        if (aok) begin
            pend_pc  = exp_addr;
            exp_addr = exp_addr + 32'd4;
        end
        drive(aok, dok, data, rdy, 1'b0, 32'h0);
        chk("out_valid", 32'(out_valid), 32'(sbq.size() != 0));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        #1;
        sbq.delete();
        pend = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{10, 0, 100, 1'b1, 1'b0};  // fill with decode stalled -> IDLE
        vt[1] = '{1,  1, 100, 1'b1, 1'b1};  // one pop -> REQ next cycle
        vt[2] = '{40, 1, 100, 1'b0, 1'b0};
        vt[3] = '{60, 2, 60,  1'b0, 1'b0};
        vt[4] = '{20, 0, 100, 1'b1, 1'b0};
        vt[5] = '{40, 2, 50,  1'b0, 1'b0};

        iresp = '0; out_ready = 0; redirect_valid = 0; redirect_pc = 0;
        pend = 0; pend_pc = 0; exp_addr = RPC;
        reset = 1'b1;
        #2;
        chk("rst_ireq_valid", 32'(ireq.valid), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        #1;
        chk("post_rst_ivalid", 32'(ireq.valid), 1);
        chk("post_rst_addr", ireq.addr, RPC);

        // First fetch after reset
        drive(1, 0, 0, 0, 0, 0);
        chk("A_wait_ivalid", 32'(ireq.valid), 0);
        drive(0, 1, 32'h2408_0001, 0, 0, 0);
        chk("A_out_valid", 32'(out_valid), 1);
        chk("A_out_pc", out_pc, RPC);
        chk("A_out_instr", out_instr, 32'h2408_0001);
        chk("A_next_addr", ireq.addr, RPC + 32'd4);
        sbq.push_back('{RPC, 32'h2408_0001});
        exp_addr = RPC + 32'd4;

        for (int i = 0; i < 6; i++) begin
            for (int c = 0; c < vt[i].ncyc; c++) cycle(vt[i].rdy_mode, vt[i].aok_pct);
            if (vt[i].chk) begin
                chk($sformatf("ph%0d_ivalid", i), 32'(ireq.valid), 32'(vt[i].exp_ivalid));
                if (vt[i].exp_ivalid) chk($sformatf("ph%0d_addr", i), ireq.addr, exp_addr);
                else if (sbq.size() != 0) chk($sformatf("ph%0d_head", i), out_pc, sbq[0].pc);
            end
        end

        // Held addr_ok, then redirect in REQ without addr_ok, then redirect while dropping
        do_reset();
        for (int c = 0; c < 3; c++) begin
            drive(0, 0, 0, 0, 0, 0);
            chk("B_hold_valid", 32'(ireq.valid), 1);
            chk("B_hold_addr", ireq.addr, RPC);
        end
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 1, memf(RPC), 0, 0, 0);
        chk("B_out_valid", 32'(out_valid), 1);
        drive(0, 0, 0, 0, 1, 32'h8000_0200);
        chk("B_redir_ivalid", 32'(ireq.valid), 1);
        chk("B_redir_oldaddr", ireq.addr, RPC + 32'd4);
        chk("B_redir_flush", 32'(out_valid), 0);
        drive(1, 0, 0, 0, 0, 0);
        chk("B_wait_ivalid", 32'(ireq.valid), 0);
        drive(0, 0, 0, 0, 1, 32'h8000_0280);
        chk("B_wait2_ivalid", 32'(ireq.valid), 0);
        drive(0, 1, 32'hdead_beef, 0, 0, 0);
        chk("B_drop_outv", 32'(out_valid), 0);
        chk("B_new_ivalid", 32'(ireq.valid), 1);
        chk("B_new_addr", ireq.addr, 32'h8000_0280);

        // Redirect in WAIT, late response discarded
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 32'h8000_0100);
        chk("C_ivalid", 32'(ireq.valid), 0);
        chk("C_outv", 32'(out_valid), 0);
        drive(0, 1, memf(32'h8000_0280), 0, 0, 0);
        chk("C_late_outv", 32'(out_valid), 0);
        chk("C_next_ivalid", 32'(ireq.valid), 1);
        chk("C_next_addr", ireq.addr, 32'h8000_0100);

        // Redirect coinciding with data_ok and a pop, FIFO holding two
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 1, memf(32'h8000_0100), 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 1, memf(32'h8000_0104), 0, 0, 0);
        chk("D_head_pc", out_pc, 32'h8000_0100);
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 1, memf(32'h8000_0108), 1, 1, 32'h9000_0000);
        chk("D_flush_outv", 32'(out_valid), 0);
        chk("D_ivalid", 32'(ireq.valid), 1);
        chk("D_addr", ireq.addr, 32'h9000_0000);
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 1, memf(32'h9000_0000), 0, 0, 0);
        chk("D_new_pc", out_pc, 32'h9000_0000);
        chk("D_new_instr", out_instr, memf(32'h9000_0000));

        // Reset asserted during WAIT
        drive(1, 0, 0, 0, 0, 0);
        chk("E_pre_outv", 32'(out_valid), 1);
        reset = 1'b1;
        #1;
        chk("E_async_outv", 32'(out_valid), 0);
        chk("E_async_ivalid", 32'(ireq.valid), 0);
        drive(0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        #1;
        chk("E_rel_ivalid", 32'(ireq.valid), 1);
        chk("E_rel_addr", ireq.addr, RPC);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'hbfc0_0000, SHALL be the fetch address loaded at reset.
REQ-002 Parameter DEPTH, default 4, SHALL set instruction-buffer entries; legal values are powers of two, >=2.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on posedge clk.
REQ-004 reset  input  1  SHALL be asynchronous, active-high reset.
REQ-005 ireq  output  ibus_req_t  SHALL carry the instruction-bus request (valid, addr).
REQ-006 iresp  input  ibus_resp_t  SHALL carry the bus response (addr_ok, data_ok, data).
REQ-007 redirect_valid  input  1  SHALL be a one-cycle pulse requesting a control-flow change.
REQ-008 redirect_pc  input  32  SHALL be the new fetch address, sampled when redirect_valid=1.
REQ-009 out_valid  output  1  SHALL be high while the buffer head holds an instruction.
REQ-010 out_ready  input  1  SHALL be high when decode accepts the head this cycle.
REQ-011 out_pc  output  32  SHALL be the PC of the head entry.
REQ-012 out_instr  output  32  SHALL be the instruction word of the head entry.

Function
REQ-013 The block SHALL hold fetch_pc, a DEPTH-entry FIFO of {pc, instr}, count, a drop flag, and an FSM with states REQ, WAIT, IDLE.
REQ-014 REQ: ireq.valid=1, ireq.addr=fetch_pc; on addr_ok SHALL latch req_pc=fetch_pc, set fetch_pc+=4 (mod 2^32), go to WAIT.
REQ-015 REQ without addr_ok: ireq.valid and ireq.addr SHALL stay unchanged the next cycle.
REQ-016 WAIT: ireq.valid=0; on data_ok, SHALL push {req_pc, iresp.data} unless drop=1 or a redirect is present that cycle, then clear drop.
REQ-017 After data_ok: next state SHALL be REQ if post-edge count < DEPTH, else IDLE.
REQ-018 IDLE: ireq.valid=0; SHALL go to REQ in the cycle after count < DEPTH.
REQ-019 At most one bus request SHALL be outstanding; a request is issued only when count + 1 <= DEPTH, so the FIFO never overflows.
REQ-020 out_valid SHALL equal (count != 0); out_pc/out_instr SHALL be the head and stay stable while out_valid=1 and out_ready=0.
REQ-021 Pop on out_valid & out_ready; simultaneous push and pop SHALL leave count unchanged; FIFO pointers wrap modulo DEPTH.
REQ-022 Redirect: fetch_pc SHALL load redirect_pc, FIFO SHALL be flushed (count=0 next cycle), independent of any same-cycle pop.
REQ-023 Redirect in REQ without addr_ok: ireq SHALL keep the old address (bus rule), drop SHALL be set; the next request after its data_ok uses redirect_pc.
REQ-024 Redirect in REQ with addr_ok, or in WAIT without data_ok: drop SHALL be set and the response discarded.
REQ-025 Redirect while drop=1: fetch_pc SHALL update to the newest redirect_pc; drop stays 1.
REQ-026 Redirect in IDLE: next state SHALL be REQ.
REQ-027 redirect_pc[1:0] SHALL pass through unchecked; alignment faults belong to decode.

Reset
REQ-028 While reset=1: state=REQ, fetch_pc=RESET_PC, count=0, drop=0, out_valid=0, ireq.valid=0; outputs set immediately (asynchronously).
REQ-029 First cycle after reset deasserts: ireq.valid=1, ireq.addr=RESET_PC.
REQ-030 Reset mid-transaction SHALL abandon the outstanding request; the bus is reset in the same event.

Verification
REQ-031 Reset release, addr_ok=1, data_ok next cycle with data 32'h2408_0001 -> following cycle out_valid=1, out_pc=32'hbfc0_0000, out_instr=32'h2408_0001.
REQ-032 out_ready=0, memory always responds -> exactly DEPTH=4 entries buffered (pcs bfc0_0000..bfc0_000c), then ireq.valid=0 (IDLE); one pop -> REQ next cycle.
REQ-033 addr_ok held 0 for 3 cycles -> ireq.addr constant for all 4 cycles.
REQ-034 Redirect to 32'h8000_0100 while in WAIT -> late response discarded, FIFO empty, next ireq.addr=32'h8000_0100.
REQ-035 Redirect on the same cycle as data_ok and as a pop with FIFO holding 2 -> count=0 next cycle, data not pushed, next request at redirect_pc.
REQ-036 Reset asserted during WAIT -> out_valid=0 immediately; after release ireq.addr=RESET_PC.
